io_ctl_buf: RTL and testbench

- Parametrised successor to the UART I/O controller.
- Sits between the UART receiver (din/d_rdy) and the UART transmitter (tx_rdy). Captures each received word into an internal FIFO, applies a selectable data transform, and hands words to the transmitter one at a time with a start strobe and busy handshake.
- Adds buffering depth, generic word width, transform modes, occupancy/overflow status and a hold switch.

---
 rtl/io_ctl_buf_pkg.sv | 51 +++++
 rtl/io_ctl_buf_if.sv | 38 +++
 rtl/io_ctl_buf_fifo.sv | 65 ++++++
 rtl/io_ctl_buf.sv | 119 +++++++++++
 tb/tb_io_ctl_buf.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_ctl_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_pkg
// Description : Shared types and the data transform for the buffered UART
//               I/O controller (mode encodings, TX state enum, xform()).
// Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

  // Widest word xform() handles; DATA_W of the controller must not exceed it.
  localparam int XF_MAX_W = 64;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_INV   = 2'b01,
    MODE_REV   = 2'b10,
    MODE_UPPER = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'b00,
    TX_SEND = 2'b01,
    TX_WAIT = 2'b10
  } tx_state_e;

  // Transform a word of 'width' valid bits (LSB-aligned in 'data').
  // Bits at and above 'width' in the result are don't-care for the caller.
  function automatic logic [XF_MAX_W-1:0] xform(input logic [XF_MAX_W-1:0] data,
                                                input int width,
                                                input mode_e mode);
    logic [XF_MAX_W-1:0] r;
    r = data;
    case (mode)
      MODE_INV: r = ~data;
      MODE_REV: begin
        r = '0;
        for (int i = 0; i < XF_MAX_W; i++) begin
          if (i < width) r[i] = data[width-1-i];
        end
      end
      MODE_UPPER: begin
        // Only the low byte is treated as ASCII; upper bits pass untouched.
        if (data[7:0] >= 8'h61 && data[7:0] <= 8'h7A) r[7:0] = data[7:0] - 8'h20;
      end
      default: r = data;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_ctl_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : io_ctl_buf_if
// Description : Receiver / transmitter / status bundle of io_ctl_buf.
//               'slave' is the controller view, 'master' the environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_ctl_buf_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              sw;
  logic [1:0]        mode;
  logic [DATA_W-1:0] din;
  logic              d_rdy;
  logic              rd;
  logic              tx_rdy;
  logic [DATA_W-1:0] dout;
  logic              tx_start;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              ovf_clr;

  modport slave (
    input  sw, mode, din, d_rdy, tx_rdy, ovf_clr,
    output rd, dout, tx_start, count, full, empty, ovf
  );

  modport master (
    output sw, mode, din, d_rdy, tx_rdy, ovf_clr,
    input  rd, dout, tx_start, count, full, empty, ovf
  );
endinterface
`default_nettype wire

// File: rtl/io_ctl_buf_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_fifo
// Description : Synchronous FIFO, combinational head read. Push while full is
//               accepted only when a pop frees a slot at the same edge; pop
//               while empty is ignored (no bypass).
// Revision    : 1.0 - initial release
// ============================================================================
module io_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       push,
  input  wire logic                       pop,
  input  wire logic [DATA_W-1:0]          wdata,
  output logic      [DATA_W-1:0]          rdata,
  output logic      [$clog2(DEPTH):0]     count,
  output logic                            full,
  output logic                            empty
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              w_do_push, w_do_pop;

  // Qualify requests against occupancy and advance pointers/count.
  always_comb begin
    w_do_pop  = pop & ~empty;
    w_do_push = push & (~full | w_do_pop);
    wr_ptr_d  = wr_ptr_q + ADDR_W'(w_do_push);
    rd_ptr_d  = rd_ptr_q + ADDR_W'(w_do_pop);
    count_d   = count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/io_ctl_buf.sv
`default_nettype none
// ============================================================================
// Module      : io_ctl_buf
// Description : Buffered UART I/O controller. Captures receiver words on the
//               rising edge of d_rdy into a FIFO, transforms each word at pop
//               time and hands it to the transmitter with a start/busy
//               handshake. Reports occupancy and a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module io_ctl_buf
  import io_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input wire logic    clk,
  input wire logic    rst,
  io_ctl_buf_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              d_rdy_q, d_rdy_d;
  logic              rd_q, rd_d;
  logic              ovf_q, ovf_d;
  logic              w_push_evt, w_pop, w_drop, w_fifo_push;
  logic [DATA_W-1:0] w_head, w_xf;
  logic [CNT_W-1:0]  w_count;
  logic              w_full, w_empty;

  tx_state_e         state_q;
  logic [DATA_W-1:0] dout_q;
  logic              tx_start_q;

  // RX edge detect, pop decision, overflow and transform of the head word.
  always_comb begin
    w_push_evt  = bus.d_rdy & ~d_rdy_q;
    w_pop       = (state_q == TX_IDLE) & bus.sw & ~w_empty & bus.tx_rdy;
    // A pop at the same edge frees a slot, so a full FIFO only drops
    // when nothing leaves.
    w_drop      = w_push_evt & w_full & ~w_pop;
    w_fifo_push = w_push_evt & ~w_drop;
    d_rdy_d     = bus.d_rdy;
    rd_d        = w_push_evt;
    ovf_d       = ovf_q;
    if (bus.ovf_clr) ovf_d = 1'b0;
    if (w_drop)      ovf_d = 1'b1;
    w_xf        = DATA_W'(xform(XF_MAX_W'(w_head), DATA_W, mode_e'(bus.mode)));
  end

  // RX handshake and status flops. d_rdy_q resets high so a level already
  // present when reset releases is not mistaken for a new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_rdy_q <= 1'b1;
      rd_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      d_rdy_q <= d_rdy_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
    end
  end

  // TX handshake FSM with registered strobe and data. WAIT holds until the
  // transmitter reports busy, so a lingering tx_rdy cannot restart it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      dout_q     <= '0;
      tx_start_q <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (w_pop) begin
            state_q    <= TX_SEND;
            dout_q     <= w_xf;
            tx_start_q <= 1'b1;
          end
        end
        TX_SEND: begin
          state_q    <= TX_WAIT;
          tx_start_q <= 1'b0;
        end
        TX_WAIT: begin
          if (!bus.tx_rdy) state_q <= TX_IDLE;
        end
        default: begin
          state_q    <= TX_IDLE;
          tx_start_q <= 1'b0;
        end
      endcase
    end
  end

  io_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_fifo_push),
    .pop   (w_pop),
    .wdata (bus.din),
    .rdata (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign bus.rd       = rd_q;
  assign bus.dout     = dout_q;
  assign bus.tx_start = tx_start_q;
  assign bus.count    = w_count;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_io_ctl_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_ctl_buf
// Description : Scoreboard bench for io_ctl_buf (DATA_W=8, DEPTH=16).
//               Expected transmit words are queued as stimulus is issued; a
//               monitor pops and compares on every tx_start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_ctl_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;

  io_ctl_buf_if #(.DATA_W(8), .DEPTH(16)) bus ();

  io_ctl_buf #(.DATA_W(8), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  int start_cnt = 0;
  logic [7:0] sbq[$];

  bit tx_auto = 1'b0;
  int busy = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one word on a fresh d_rdy rising edge, optionally queueing the
  // word the transmitter is expected to receive for it.
  task automatic push_word(input logic [7:0] d, input bit exp_en, input logic [7:0] e);
    bus.din   = d;
    bus.d_rdy = 1'b1;
    if (exp_en) sbq.push_back(e);
    tick();
    bus.d_rdy = 1'b0;
    tick();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(sbq.size()), 32'd0);
  endtask

  // Monitor: counts rd pulses and scores every transmitted word.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (bus.rd) rd_cnt++;
      if (bus.tx_start) begin
        start_cnt++;
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected tx_start: dout=%0h with no word expected", bus.dout);
        end else begin
          e = sbq.pop_front();
          if (bus.dout !== e) begin
            bad++;
            $display("FAIL tx dout: got %0h expected %0h", bus.dout, e);
          end
        end
      end
    end
  end

  // Transmitter model: idle-high, busy for a few cycles after each start.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_auto) begin
        if (bus.tx_start) begin
          bus.tx_rdy = 1'b0;
          busy = 3;
        end else if (busy > 0) begin
          busy--;
          if (busy == 0) bus.tx_rdy = 1'b1;
        end else begin
          bus.tx_rdy = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int rd0, sc0;
    bus.sw = 1'b0; bus.mode = 2'b00; bus.din = '0; bus.d_rdy = 1'b1;
    bus.tx_rdy = 1'b0; bus.ovf_clr = 1'b0;

    // Reset with d_rdy held high.
    rst = 1'b1;
    repeat (3) tick();
    check("rst rd", 32'(bus.rd), 32'd0);
    check("rst dout", 32'(bus.dout), 32'd0);
    check("rst tx_start", 32'(bus.tx_start), 32'd0);
    check("rst count", 32'(bus.count), 32'd0);
    check("rst empty", 32'(bus.empty), 32'd1);
    check("rst full", 32'(bus.full), 32'd0);
    check("rst ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("held d_rdy count", 32'(bus.count), 32'd0);
    check("held d_rdy rd", 32'(rd_cnt), 32'd0);
    bus.d_rdy = 1'b0;
    tick();
    bus.mode = 2'b11;
    bus.din = 8'h33;
    bus.d_rdy = 1'b1;
    sbq.push_back(8'h33);
    tick();
    check("first push count", 32'(bus.count), 32'd1);
    check("first push rd", 32'(bus.rd), 32'd1);
    repeat (3) tick();
    check("held high captures once", 32'(bus.count), 32'd1);
    bus.d_rdy = 1'b0;
    tick();
    check("rd pulses", 32'(rd_cnt), 32'd1);

    // Upper-case transform with transmitter model running.
    sc0 = start_cnt;
    tx_auto = 1'b1;
    bus.sw = 1'b1;
    push_word(8'h61, 1'b1, 8'h41);
    push_word(8'h42, 1'b1, 8'h42);
    push_word(8'h7A, 1'b1, 8'h5A);
    drain("drain upper", 60);
    repeat (6) tick();
    check("upper starts", 32'(start_cnt - sc0), 32'd4);
    check("upper empty", 32'(bus.empty), 32'd1);

    // Overflow: 17 words into a 16-deep FIFO while held.
    bus.sw = 1'b0;
    bus.mode = 2'b00;
    rd0 = rd_cnt;
    for (int i = 0; i < 16; i++) push_word(8'(i), 1'b1, 8'(i));
    check("fill count", 32'(bus.count), 32'd16);
    check("fill full", 32'(bus.full), 32'd1);
    check("fill ovf", 32'(bus.ovf), 32'd0);
    push_word(8'h10, 1'b0, 8'h00);
    check("ovf set", 32'(bus.ovf), 32'd1);
    check("ovf count", 32'(bus.count), 32'd16);
    check("ovf rd pulses", 32'(rd_cnt - rd0), 32'd17);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf clr", 32'(bus.ovf), 32'd0);
    bus.sw = 1'b1;
    drain("drain overflow", 200);
    repeat (6) tick();
    check("ovf drained empty", 32'(bus.empty), 32'd1);

    // Mode is applied at pop time, not at capture time.
    bus.sw = 1'b0;
    push_word(8'h01, 1'b1, 8'h80);
    push_word(8'h2C, 1'b1, 8'h34);
    bus.mode = 2'b10;
    bus.sw = 1'b1;
    drain("drain reverse", 40);
    repeat (6) tick();

    // tx_rdy held high after a start: no second start until it toggles.
    bus.sw = 1'b0;
    tx_auto = 1'b0;
    bus.tx_rdy = 1'b0;
    bus.mode = 2'b01;
    push_word(8'h5C, 1'b1, 8'hA3);
    push_word(8'h3C, 1'b1, 8'hC3);
    sc0 = start_cnt;
    bus.sw = 1'b1;
    bus.tx_rdy = 1'b1;
    repeat (6) tick();
    check("held tx_rdy one start", 32'(start_cnt - sc0), 32'd1);
    bus.tx_rdy = 1'b0;
    tick();
    bus.tx_rdy = 1'b1;
    repeat (3) tick();
    check("restart after toggle", 32'(start_cnt - sc0), 32'd2);
    bus.tx_rdy = 1'b0;
    repeat (2) tick();
    bus.sw = 1'b0;

    // Full FIFO with push and pop at the same edge.
    bus.mode = 2'b00;
    for (int i = 0; i < 16; i++) push_word(8'(8'h80 + i), 1'b1, 8'(8'h80 + i));
    check("sim full", 32'(bus.full), 32'd1);
    bus.din = 8'h9A;
    bus.d_rdy = 1'b1;
    bus.sw = 1'b1;
    bus.tx_rdy = 1'b1;
    sbq.push_back(8'h9A);
    tick();
    check("sim count", 32'(bus.count), 32'd16);
    check("sim ovf", 32'(bus.ovf), 32'd0);
    check("sim rd", 32'(bus.rd), 32'd1);
    bus.d_rdy = 1'b0;
    bus.tx_rdy = 1'b0;
    repeat (2) tick();
    busy = 0;
    tx_auto = 1'b1;
    drain("drain simultaneous", 200);
    repeat (6) tick();
    check("sim empty", 32'(bus.empty), 32'd1);

    // Reset while in WAIT with five words queued.
    bus.sw = 1'b0;
    tx_auto = 1'b0;
    bus.tx_rdy = 1'b0;
    tick();
    push_word(8'h10, 1'b1, 8'h10);
    for (int i = 1; i < 6; i++) push_word(8'(8'h10 + i), 1'b0, 8'h00);
    bus.sw = 1'b1;
    bus.tx_rdy = 1'b1;
    repeat (2) tick();
    bus.sw = 1'b0;
    tick();
    check("wait count", 32'(bus.count), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wait rst tx_start", 32'(bus.tx_start), 32'd0);
    check("wait rst dout", 32'(bus.dout), 32'd0);
    check("wait rst count", 32'(bus.count), 32'd0);
    check("wait rst empty", 32'(bus.empty), 32'd1);
    tick();
    sc0 = start_cnt;
    bus.sw = 1'b1;
    push_word(8'h77, 1'b1, 8'h77);
    drain("post reset idle", 20);
    check("post reset start", 32'(start_cnt - sc0), 32'd1);
    repeat (4) tick();
    check("queue empty at end", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
